bcd_updown_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_cell.sv | 41 ++++
 rtl/bcd_updown_counter.sv | 143 ++++++++++++++
 tb/tb_bcd_updown_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load-clamp helper used by the
// up/down BCD counter and its per-digit cell.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Non-decimal codes (A..F) are forced to 9 so a digit register never leaves 0..9.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with clear, clamped parallel load and single-step
// up/down counting; reports whether it sits at 9 or at 0 for the ripple chain.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       en_up,
  input  logic       en_dn,
  input  logic       load,
  input  bcd_digit_t load_digit,
  output bcd_digit_t digit,
  output logic       is_max,
  output logic       is_min
);

  bcd_digit_t digit_next;

  always_comb begin
    digit_next = digit;
    if (load) begin
      digit_next = bcd_clamp(load_digit);
    end else if (en_up) begin
      digit_next = (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
    end else if (en_dn) begin
      digit_next = (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      digit <= BCD_MIN;
    end else begin
      digit <= digit_next;
    end
  end

  assign is_max = (digit == BCD_MAX);
  assign is_min = (digit == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clamped parallel load, wrap/saturate
// mode, carry/borrow pulses and sticky overflow. Optional leading-zero blank
// output when BCD_UPDOWN_BLANK_EN is defined.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int BCD_NUM  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       incr,
  input  logic       decr,
  input  logic       reset_counter,
  input  logic       load,
  input  bcd_digit_t load_value [BCD_NUM-1:0],
  input  logic       sat_mode,
  output bcd_digit_t bcds [BCD_NUM-1:0],
  output logic       carry_out,
  output logic       borrow_out,
  output logic       overflow,
  output logic       at_max,
  output logic       at_zero,
  output logic       load_err
`ifdef BCD_UPDOWN_BLANK_EN
  ,
  output logic [BCD_NUM-1:0] blank
`endif
);

  logic               clear;
  logic               do_load;
  logic               load_bad;
  logic               req_up;
  logic               req_dn;
  logic               wrap_up;
  logic               wrap_dn;
  logic               hit_limit;
  logic               step_up;
  logic               step_dn;
  logic               mode_q;
  logic               run_up;
  logic               run_dn;
  logic [BCD_NUM-1:0] en_up;
  logic [BCD_NUM-1:0] en_dn;
  logic [BCD_NUM-1:0] is_max;
  logic [BCD_NUM-1:0] is_min;

  // Mode bit is re-sampled from sat_mode every cycle; SATURATE only seeds it out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= SATURATE;
    end else begin
      mode_q <= sat_mode;
    end
  end

  assign clear   = reset | reset_counter;
  assign do_load = ~clear & load;
  assign req_up  = ~clear & ~load & incr & ~decr;
  assign req_dn  = ~clear & ~load & decr & ~incr;

  always_comb begin
    load_bad = 1'b0;
    for (int i = 0; i < BCD_NUM; i++) begin
      load_bad = load_bad | ~bcd_is_valid(load_value[i]);
    end
  end

  always_comb begin
    at_max = 1'b1;
    at_zero = 1'b1;
    for (int i = 0; i < BCD_NUM; i++) begin
      at_max  = at_max & is_max[i];
      at_zero = at_zero & is_min[i];
    end
  end

  assign hit_limit = (req_up & at_max) | (req_dn & at_zero);
  assign wrap_up   = req_up & at_max & ~mode_q;
  assign wrap_dn   = req_dn & at_zero & ~mode_q;
  assign step_up   = req_up & ~(at_max & mode_q);
  assign step_dn   = req_dn & ~(at_zero & mode_q);

  // Ripple enables: a digit moves only when every lower digit is at its limit.
  always_comb begin
    en_up  = '0;
    en_dn  = '0;
    run_up = step_up;
    run_dn = step_dn;
    for (int i = 0; i < BCD_NUM; i++) begin
      en_up[i] = run_up;
      en_dn[i] = run_dn;
      run_up   = run_up & is_max[i];
      run_dn   = run_dn & is_min[i];
    end
  end

  for (genvar g = 0; g < BCD_NUM; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .clear      (clear),
      .en_up      (en_up[g]),
      .en_dn      (en_dn[g]),
      .load       (do_load),
      .load_digit (load_value[g]),
      .digit      (bcds[g]),
      .is_max     (is_max[g]),
      .is_min     (is_min[g])
    );
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      carry_out  <= wrap_up;
      borrow_out <= wrap_dn;
      load_err   <= do_load & load_bad;
      if (hit_limit) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef BCD_UPDOWN_BLANK_EN
  logic blank_run;

  // Decoded from the digit registers, so blank changes on the same edge as bcds.
  always_comb begin
    blank     = '0;
    blank_run = 1'b1;
    for (int i = BCD_NUM - 1; i >= 1; i--) begin
      blank_run = blank_run & is_min[i];
      blank[i]  = blank_run;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed-vector bench for bcd_updown_counter with two digits; blank checks
// are compiled in only when BCD_UPDOWN_BLANK_EN is defined.
module tb_bcd_updown_counter;
  import bcd_pkg::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       incr;
  logic       decr;
  logic       reset_counter;
  logic       load;
  bcd_digit_t load_value [N-1:0];
  logic       sat_mode;
  bcd_digit_t bcds [N-1:0];
  logic       carry_out;
  logic       borrow_out;
  logic       overflow;
  logic       at_max;
  logic       at_zero;
  logic       load_err;
`ifdef BCD_UPDOWN_BLANK_EN
  logic [N-1:0] blank;
`endif

  int n_vec = 0;
  int n_err = 0;
  int n_carry;
  int n_borrow;
  int n_lerr;

  bcd_updown_counter #(.BCD_NUM(N), .SATURATE(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .incr          (incr),
    .decr          (decr),
    .reset_counter (reset_counter),
    .load          (load),
    .load_value    (load_value),
    .sat_mode      (sat_mode),
    .bcds          (bcds),
    .carry_out     (carry_out),
    .borrow_out    (borrow_out),
    .overflow      (overflow),
    .at_max        (at_max),
    .at_zero       (at_zero),
    .load_err      (load_err)
`ifdef BCD_UPDOWN_BLANK_EN
    ,
    .blank         (blank)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] value();
    return {24'd0, bcds[1], bcds[0]};
  endfunction

  // Advance one edge, sample 1 ns later and tally pulses seen.
  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      n_carry  += int'(carry_out);
      n_borrow += int'(borrow_out);
      n_lerr   += int'(load_err);
    end
  endtask

  task automatic clear_tally();
    n_carry = 0;
    n_borrow = 0;
    n_lerr = 0;
  endtask

  task automatic do_load(input bcd_digit_t d1, input bcd_digit_t d0);
    load_value[1] = d1;
    load_value[0] = d0;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear_tally();
    reset = 1'b1;
    incr = 1'b0;
    decr = 1'b0;
    reset_counter = 1'b0;
    load = 1'b0;
    load_value[1] = 4'd0;
    load_value[0] = 4'd0;
    sat_mode = 1'b0;
    step(2);
    check("reset_value", value(), 32'h00);
    check("reset_at_zero", {31'd0, at_zero}, 32'd1);
    check("reset_at_max", {31'd0, at_max}, 32'd0);
    check("reset_flags", {28'd0, carry_out, borrow_out, overflow, load_err}, 32'd0);
`ifdef BCD_UPDOWN_BLANK_EN
    check("reset_blank", {30'd0, blank}, 32'b10);
`endif

    // Idle
    reset = 1'b0;
    clear_tally();
    step(30);
    check("idle_value", value(), 32'h00);
    check("idle_at_zero", {31'd0, at_zero}, 32'd1);
    check("idle_pulses", n_carry + n_borrow, 0);

    // Count up 30, crossing digit boundaries
    incr = 1'b1;
    step(30);
    incr = 1'b0;
    check("up30_value", value(), 32'h30);
    check("up30_overflow", {31'd0, overflow}, 32'd0);
    check("up30_at_zero", {31'd0, at_zero}, 32'd0);
    decr = 1'b1;
    step();
    decr = 1'b0;
    check("dn_borrow_digit", value(), 32'h29);
    check("dn_no_borrow_out", {31'd0, borrow_out}, 32'd0);

    // Wrap up from 99
    do_load(4'd9, 4'd9);
    check("load99_value", value(), 32'h99);
    check("load99_at_max", {31'd0, at_max}, 32'd1);
    check("load99_no_err", {31'd0, load_err}, 32'd0);
    clear_tally();
    incr = 1'b1;
    step();
    incr = 1'b0;
    check("wrap_up_value", value(), 32'h00);
    check("wrap_up_carry", {31'd0, carry_out}, 32'd1);
    check("wrap_up_overflow", {31'd0, overflow}, 32'd1);
    step(3);
    check("wrap_up_carry_once", n_carry, 1);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    reset_counter = 1'b1;
    step();
    reset_counter = 1'b0;
    check("rc_overflow", {31'd0, overflow}, 32'd0);

    // Wrap down from 00
    clear_tally();
    decr = 1'b1;
    step();
    decr = 1'b0;
    check("wrap_dn_value", value(), 32'h99);
    check("wrap_dn_borrow", {31'd0, borrow_out}, 32'd1);
    check("wrap_dn_overflow", {31'd0, overflow}, 32'd1);
    step();
    check("wrap_dn_borrow_once", n_borrow, 1);

    // Saturate down at 00 (mode set a cycle ahead of use)
    sat_mode = 1'b1;
    reset_counter = 1'b1;
    step();
    reset_counter = 1'b0;
    clear_tally();
    decr = 1'b1;
    step(5);
    decr = 1'b0;
    check("sat_dn_value", value(), 32'h00);
    check("sat_dn_no_borrow", n_borrow, 0);
    check("sat_dn_overflow", {31'd0, overflow}, 32'd1);

    // Load keeps overflow; saturate up at 99
    do_load(4'd9, 4'd9);
    check("load_keeps_overflow", {31'd0, overflow}, 32'd1);
    clear_tally();
    incr = 1'b1;
    step(3);
    incr = 1'b0;
    check("sat_up_value", value(), 32'h99);
    check("sat_up_no_carry", n_carry, 0);

    // Load clamp with incr pending
    sat_mode = 1'b0;
    reset_counter = 1'b1;
    step();
    reset_counter = 1'b0;
    clear_tally();
    load_value[1] = 4'd1;
    load_value[0] = 4'hA;
    load = 1'b1;
    incr = 1'b1;
    step();
    load = 1'b0;
    incr = 1'b0;
    check("clamp_value", value(), 32'h19);
    check("clamp_load_err", {31'd0, load_err}, 32'd1);
    step();
    check("clamp_err_once", n_lerr, 1);
    check("clamp_overflow", {31'd0, overflow}, 32'd0);
    incr = 1'b1;
    decr = 1'b1;
    step(3);
    incr = 1'b0;
    decr = 1'b0;
    check("both_hold", value(), 32'h19);
    check("both_no_pulse", n_carry + n_borrow, 0);
    do_load(4'hF, 4'd3);
    check("clamp_hi_value", value(), 32'h93);
    check("clamp_hi_err", {31'd0, load_err}, 32'd1);

    // Priority: reset_counter over load; reset over incr
    load_value[1] = 4'd5;
    load_value[0] = 4'd5;
    load = 1'b1;
    reset_counter = 1'b1;
    step();
    load = 1'b0;
    reset_counter = 1'b0;
    check("rc_over_load", value(), 32'h00);
    incr = 1'b1;
    step(7);
    check("count7", value(), 32'h07);
    reset = 1'b1;
    step();
    reset = 1'b0;
    incr = 1'b0;
    check("reset_mid_count", value(), 32'h00);

`ifdef BCD_UPDOWN_BLANK_EN
    do_load(4'd0, 4'd5);
    check("blank_05", {30'd0, blank}, 32'b10);
    do_load(4'd4, 4'd0);
    check("blank_40", {30'd0, blank}, 32'b00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
